// File: rtl/pipeline_control_sequencer_pkg.sv
// Shared definitions for the pipeline control sequencer: FSM state encoding and
// the RV32I control-transfer/upper-immediate opcodes used around the hazard path.
package pipeline_control_sequencer_pkg;

   typedef enum logic {
      RUN      = 1'b0,
      MEM_WAIT = 1'b1
   } seq_state_t;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   function automatic logic is_control_transfer(input logic [6:0] opcode);
      return (opcode == OP_BRANCH) || (opcode == OP_JAL) || (opcode == OP_JALR);
   endfunction

endpackage

// File: rtl/pipeline_control_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; stops at all-ones instead of wrapping.
module sat_counter
   import pipeline_control_sequencer_pkg::*;
#(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);

   logic [W-1:0] q_reg;

   always_ff @(posedge clk) begin
      if (clr) begin
         q_reg <= '0;
      end else if (inc && (q_reg != '1)) begin
         q_reg <= q_reg + W'(1);
      end
   end

   assign q = q_reg;

endmodule

// File: rtl/pipeline_control_sequencer.sv
// Stall/flush sequencer for the 5-stage RV32I pipeline: merges hazard stalls, ID redirects
// and memory handshakes into per-stage enables/flushes, with perf counters and a wait watchdog.
module pipeline_control_sequencer
   import pipeline_control_sequencer_pkg::*;
#(
   parameter int CNT_W       = 32,
   parameter int MEM_TIMEOUT = 255,
   parameter int TO_W        = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             hdu_stall,
   input  logic             id_redirect,
   input  logic             imem_ready,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   output logic             pc_write,
   output logic             if_id_write,
   output logic             if_id_flush,
   output logic             id_ex_write,
   output logic             id_ex_flush,
   output logic             ex_mem_write,
   output logic             mem_wb_write,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt,
   output logic             mem_timeout
);

   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(MEM_TIMEOUT);

   seq_state_t      state_reg, state_next;
   logic            redirect_pend_reg, redirect_pend_next;
   logic [TO_W-1:0] wait_cnt_reg, wait_cnt_next;
   logic            mem_timeout_reg, mem_timeout_next;
   logic            wait_start, freeze, flush_event;

   always_comb begin
      wait_start         = (state_reg == RUN) && dmem_req && !dmem_ready;
      freeze             = wait_start || ((state_reg == MEM_WAIT) && !dmem_ready);
      pc_write           = 1'b1;
      if_id_write        = 1'b1;
      id_ex_write        = 1'b1;
      ex_mem_write       = 1'b1;
      mem_wb_write       = 1'b1;
      if_id_flush        = 1'b0;
      id_ex_flush        = 1'b0;
      mem_wb_flush       = 1'b0;
      flush_event        = 1'b0;
      redirect_pend_next = redirect_pend_reg;
      state_next         = state_reg;
      wait_cnt_next      = wait_cnt_reg;
      mem_timeout_next   = mem_timeout_reg;

      if (reset) begin
         pc_write     = 1'b0;
         if_id_write  = 1'b0;
         id_ex_write  = 1'b0;
         ex_mem_write = 1'b0;
         mem_wb_write = 1'b0;
         if_id_flush  = 1'b1;
         id_ex_flush  = 1'b1;
         mem_wb_flush = 1'b1;
      end else begin
         // A frozen ID stage keeps presenting hdu_stall/id_redirect, so masking them loses nothing.
         if (freeze) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            mem_wb_write = 1'b0;
            mem_wb_flush = 1'b1;
         end else if (hdu_stall) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
         end else if (id_redirect) begin
            if_id_flush        = 1'b1;
            flush_event        = 1'b1;
            redirect_pend_next = redirect_pend_reg || !imem_ready;
         end else if (redirect_pend_reg && imem_ready) begin
            if_id_flush        = 1'b1;
            redirect_pend_next = 1'b0;
         end else if (!imem_ready) begin
            pc_write    = 1'b0;
            if_id_flush = 1'b1;
         end

         case (state_reg)
            RUN:      if (wait_start) state_next = MEM_WAIT;
            MEM_WAIT: if (dmem_ready) state_next = RUN;
            default:  state_next = RUN;
         endcase

         // Timeout flag rises together with wait_cnt reaching the limit, then both hold.
         if (wait_start) begin
            wait_cnt_next = '0;
         end else if (state_reg == MEM_WAIT) begin
            if (wait_cnt_reg != TO_LIMIT) wait_cnt_next = wait_cnt_reg + TO_W'(1);
            if (wait_cnt_next == TO_LIMIT) mem_timeout_next = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg         <= RUN;
         redirect_pend_reg <= 1'b0;
         wait_cnt_reg      <= '0;
         mem_timeout_reg   <= 1'b0;
      end else begin
         state_reg         <= state_next;
         redirect_pend_reg <= redirect_pend_next;
         wait_cnt_reg      <= wait_cnt_next;
         mem_timeout_reg   <= mem_timeout_next;
      end
   end

   assign mem_timeout = mem_timeout_reg;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk (clk),
      .clr (reset),
      .inc (!pc_write && !reset),
      .q   (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk (clk),
      .clr (reset),
      .inc (flush_event),
      .q   (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_control_sequencer.sv
// Self-checking bench for pipeline_control_sequencer: directed scenarios plus a randomized
// run, all checked against a cycle-level behavioural model of the sequencing rules.
module tb_pipeline_control_sequencer;

   localparam int CNT_W       = 3;
   localparam int MEM_TIMEOUT = 4;
   localparam int TO_W        = 8;
   localparam int CMAX        = (1 << CNT_W) - 1;

   // {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush, ex_mem_write, mem_wb_write, mem_wb_flush}
   localparam logic [7:0] CTL_RESET  = 8'b0010_1001;
   localparam logic [7:0] CTL_FREEZE = 8'b0000_0001;
   localparam logic [7:0] CTL_HDU    = 8'b0001_1110;
   localparam logic [7:0] CTL_REDIR  = 8'b1111_0110;
   localparam logic [7:0] CTL_FETCH  = 8'b0111_0110;
   localparam logic [7:0] CTL_RUN    = 8'b1101_0110;

   logic             clk = 1'b0;
   logic             reset, hdu_stall, id_redirect, imem_ready, dmem_req, dmem_ready;
   logic             pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
   logic             ex_mem_write, mem_wb_write, mem_wb_flush, mem_timeout;
   logic [CNT_W-1:0] stall_cnt, flush_cnt;
   logic [7:0]       ctl;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Behavioural model state: plain flags and unbounded integer counts.
   bit         m_wait, m_pend, m_to;
   int         m_stall, m_flush, m_wcnt;
   int         exp_rule;
   logic [7:0] exp_ctl;

   always #5 clk = ~clk;

   assign ctl = {pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                 ex_mem_write, mem_wb_write, mem_wb_flush};

   pipeline_control_sequencer #(
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT),
      .TO_W        (TO_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .hdu_stall    (hdu_stall),
      .id_redirect  (id_redirect),
      .imem_ready   (imem_ready),
      .dmem_req     (dmem_req),
      .dmem_ready   (dmem_ready),
      .pc_write     (pc_write),
      .if_id_write  (if_id_write),
      .if_id_flush  (if_id_flush),
      .id_ex_write  (id_ex_write),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_write (ex_mem_write),
      .mem_wb_write (mem_wb_write),
      .mem_wb_flush (mem_wb_flush),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt),
      .mem_timeout  (mem_timeout)
   );

   // 0 reset, 1 freeze, 2 stall, 3 redirect, 4 pending squash, 5 fetch wait, 6 normal
   function automatic int rule_of(bit rst, bit hs, bit rd, bit ir, bit dq, bit dr);
      bit frozen;
      frozen = m_wait ? !dr : (dq && !dr);
      if (rst)              return 0;
      if (frozen)           return 1;
      if (hs)               return 2;
      if (rd)               return 3;
      if (m_pend && ir)     return 4;
      if (!ir)              return 5;
      return 6;
   endfunction

   function automatic logic [7:0] ctl_of(int r);
      case (r)
         0:       return CTL_RESET;
         1:       return CTL_FREEZE;
         2:       return CTL_HDU;
         3, 4:    return CTL_REDIR;
         5:       return CTL_FETCH;
         default: return CTL_RUN;
      endcase
   endfunction

   task automatic drive(input bit rst, input bit hs, input bit rd, input bit ir,
                        input bit dq, input bit dr);
      reset       = rst;
      hdu_stall   = hs;
      id_redirect = rd;
      imem_ready  = ir;
      dmem_req    = dq;
      dmem_ready  = dr;
      exp_rule    = rule_of(rst, hs, rd, ir, dq, dr);
      exp_ctl     = ctl_of(exp_rule);
      @(negedge clk);
   endtask

   task automatic tick();
      @(posedge clk);
      $display("cyc=%0d rst=%b hs=%b rd=%b ir=%b dq=%b dr=%b ctl=%b stall=%0d flush=%0d to=%b",
               cyc, reset, hdu_stall, id_redirect, imem_ready, dmem_req, dmem_ready,
               ctl, stall_cnt, flush_cnt, mem_timeout);
      cyc++;
      if (reset) begin
         m_wait = 0; m_pend = 0; m_to = 0;
         m_stall = 0; m_flush = 0; m_wcnt = 0;
      end else begin
         if (!exp_ctl[7]) m_stall = (m_stall + 1 > CMAX) ? CMAX : m_stall + 1;
         if (exp_rule == 3) begin
            m_flush = (m_flush + 1 > CMAX) ? CMAX : m_flush + 1;
            if (!imem_ready) m_pend = 1;
         end
         if (exp_rule == 4) m_pend = 0;
         if (m_wait) begin
            m_wcnt++;
            if (m_wcnt >= MEM_TIMEOUT) m_to = 1;
            if (dmem_ready) m_wait = 0;
         end else if (dmem_req && !dmem_ready) begin
            m_wait = 1;
            m_wcnt = 0;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         drive(1, 0, 0, 1, 0, 0);
         total++;
         if (ctl !== CTL_RESET) begin
            $display("FAIL reset_ctl cycle %0d: got %b want %b", i, ctl, CTL_RESET);
            bad++;
         end
         tick();
      end
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (ctl !== CTL_RUN) begin
         $display("FAIL reset_release_ctl: got %b want %b", ctl, CTL_RUN);
         bad++;
      end
      total++;
      if (stall_cnt !== '0 || flush_cnt !== '0 || mem_timeout !== 1'b0) begin
         $display("FAIL reset_state: stall=%0d flush=%0d to=%b want 0 0 0", stall_cnt, flush_cnt, mem_timeout);
         bad++;
      end
      tick();
   endtask

   task automatic test_data_wait();
      int s0;
      s0 = m_stall;
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 0, 1, 1, i == 3);
         total++;
         if (ctl !== exp_ctl || ctl !== ((i == 3) ? CTL_RUN : CTL_FREEZE)) begin
            $display("FAIL data_wait_ctl cycle %0d: got %b want %b", i, ctl, exp_ctl);
            bad++;
         end
         tick();
      end
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (stall_cnt !== CNT_W'(s0 + 3) || ctl !== CTL_RUN) begin
         $display("FAIL data_wait_release: stall=%0d ctl=%b want stall=%0d ctl=%b",
                  stall_cnt, ctl, s0 + 3, CTL_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_stall_beats_redirect();
      int f0;
      f0 = m_flush;
      drive(0, 1, 1, 1, 0, 0);
      total++;
      if (pc_write !== 1'b0 || id_ex_flush !== 1'b1 || if_id_flush !== 1'b0 || ctl !== exp_ctl) begin
         $display("FAIL stall_redirect_ctl: got %b want %b", ctl, CTL_HDU);
         bad++;
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (flush_cnt !== CNT_W'(f0) || ctl !== CTL_RUN) begin
         $display("FAIL stall_redirect_flush_cnt: got %0d ctl=%b want %0d ctl=%b", flush_cnt, ctl, f0, CTL_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_slow_fetch();
      logic [7:0] want [5];
      int f0;
      want = '{CTL_REDIR, CTL_FETCH, CTL_FETCH, CTL_REDIR, CTL_RUN};
      f0 = m_flush;
      for (int i = 0; i < 5; i++) begin
         drive(0, 0, i == 0, i >= 3, 0, 0);
         total++;
         if (ctl !== want[i] || ctl !== exp_ctl) begin
            $display("FAIL slow_fetch_ctl step %0d: got %b want %b", i, ctl, want[i]);
            bad++;
         end
         tick();
      end
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (flush_cnt !== CNT_W'(f0 + 1)) begin
         $display("FAIL slow_fetch_flush_cnt: got %0d want %0d", flush_cnt, f0 + 1);
         bad++;
      end
      tick();
   endtask

   task automatic test_watchdog();
      for (int i = 0; i < 10; i++) begin
         drive(0, 0, 0, 1, 1, 0);
         total++;
         if (ctl !== CTL_FREEZE || mem_timeout !== (i >= MEM_TIMEOUT + 1) || mem_timeout !== m_to) begin
            $display("FAIL watchdog_wait cycle %0d: ctl=%b to=%b want ctl=%b to=%b",
                     i, ctl, mem_timeout, CTL_FREEZE, i >= MEM_TIMEOUT + 1);
            bad++;
         end
         tick();
      end
      drive(0, 0, 0, 1, 1, 1);
      total++;
      if (ctl !== CTL_RUN || mem_timeout !== 1'b1) begin
         $display("FAIL watchdog_release: ctl=%b to=%b want ctl=%b to=1", ctl, mem_timeout, CTL_RUN);
         bad++;
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (ctl !== CTL_RUN || mem_timeout !== 1'b1) begin
         $display("FAIL watchdog_after: ctl=%b to=%b want ctl=%b to=1", ctl, mem_timeout, CTL_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_saturation();
      drive(1, 0, 0, 1, 0, 0);
      tick();
      for (int i = 0; i < 9; i++) begin
         drive(0, 1, 0, 1, 0, 0);
         total++;
         if (ctl !== CTL_HDU || stall_cnt !== CNT_W'(m_stall)) begin
            $display("FAIL saturation_stall cycle %0d: ctl=%b stall=%0d want ctl=%b stall=%0d",
                     i, ctl, stall_cnt, CTL_HDU, m_stall);
            bad++;
         end
         tick();
      end
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (stall_cnt !== CNT_W'(CMAX)) begin
         $display("FAIL saturation_value: got %0d want %0d", stall_cnt, CMAX);
         bad++;
      end
      tick();
      for (int i = 0; i < 2; i++) begin
         drive(0, 0, 0, 1, 1, 0);
         tick();
      end
      drive(1, 0, 0, 1, 1, 0);
      total++;
      if (ctl !== CTL_RESET) begin
         $display("FAIL reset_mid_wait_ctl: got %b want %b", ctl, CTL_RESET);
         bad++;
      end
      tick();
      drive(0, 0, 0, 1, 0, 0);
      total++;
      if (ctl !== CTL_RUN || stall_cnt !== '0 || mem_timeout !== 1'b0) begin
         $display("FAIL reset_mid_wait_after: ctl=%b stall=%0d to=%b want ctl=%b stall=0 to=0",
                  ctl, stall_cnt, mem_timeout, CTL_RUN);
         bad++;
      end
      tick();
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         drive($urandom_range(0, 39) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 4) == 0,
               $urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 0);
         total++;
         if (ctl !== exp_ctl || stall_cnt !== CNT_W'(m_stall) || flush_cnt !== CNT_W'(m_flush) ||
             mem_timeout !== m_to) begin
            $display("FAIL random cycle %0d: ctl=%b stall=%0d flush=%0d to=%b want ctl=%b stall=%0d flush=%0d to=%b",
                     i, ctl, stall_cnt, flush_cnt, mem_timeout, exp_ctl, m_stall, m_flush, m_to);
            bad++;
         end
         tick();
      end
   endtask

   initial begin
      reset = 1'b1; hdu_stall = 1'b0; id_redirect = 1'b0;
      imem_ready = 1'b1; dmem_req = 1'b0; dmem_ready = 1'b0;
      exp_rule = 0; exp_ctl = CTL_RESET;
      @(posedge clk);
      #1;
      test_reset();
      test_data_wait();
      test_stall_beats_redirect();
      test_slow_fetch();
      test_watchdog();
      test_saturation();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
